load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: single-beat bus master with byte/half/word access, sign/zero extension.
// Define MISALIGNED_SPLIT_EN to split word-crossing accesses into two bus phases; otherwise they are errors.
module load_store_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_write_data,
  output logic        resp_valid,
  output logic [31:0] resp_read_data,
  output logic        resp_error,
  output logic [31:0] bus_address,
  input  logic [31:0] bus_read_data,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  output logic        bus_read_enable,
  output logic        bus_write_enable
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ACCESS_LO  = 3'd1,
    CAPTURE_LO = 3'd2,
    ACCESS_HI  = 3'd3,
    CAPTURE_HI = 3'd4,
    RESPOND    = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_write;
  logic        r_unsigned;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_lo;

  logic        w_idle;
  logic        w_write;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_mask;
  logic [31:0] w_wmasked;
  logic [7:0]  w_be8;
  logic [63:0] w_wdata64;
  logic [31:0] w_word_addr;
  logic        w_need_hi;
  logic        w_error;
  logic [55:0] w_rd56;
  logic [31:0] w_raw;
  logic [31:0] w_ext;

  // Outputs are registered from the next state, so while idle the live request is decoded.
  assign w_idle      = (r_state == IDLE);
  assign w_write     = w_idle ? req_write      : r_write;
  assign w_size      = w_idle ? req_size       : r_size;
  assign w_addr      = w_idle ? req_address    : r_addr;
  assign w_wdata     = w_idle ? req_write_data : r_wdata;
  assign req_ready   = w_idle;
  assign w_word_addr = {w_addr[31:2], 2'b00};
  assign w_be8       = {4'b0000, w_mask} << w_addr[1:0];
  assign w_wdata64   = {32'h0000_0000, w_wmasked} << {w_addr[1:0], 3'b000};

  always_comb begin
    w_mask    = 4'b0000;
    w_wmasked = 32'h0000_0000;
    case (w_size)
      2'd0: begin
        w_mask    = 4'b0001;
        w_wmasked = {24'h00_0000, w_wdata[7:0]};
      end
      2'd1: begin
        w_mask    = 4'b0011;
        w_wmasked = {16'h0000, w_wdata[15:0]};
      end
      2'd2: begin
        w_mask    = 4'b1111;
        w_wmasked = w_wdata;
      end
      default: begin
        w_mask    = 4'b0000;
        w_wmasked = 32'h0000_0000;
      end
    endcase
  end

`ifdef MISALIGNED_SPLIT_EN
  assign w_need_hi = |w_be8[7:4];
  assign w_error   = (w_size == 2'd3);
`else
  logic w_misaligned;
  assign w_misaligned = ((w_size == 2'd1) && w_addr[0]) ||
                        ((w_size == 2'd2) && (w_addr[1:0] != 2'b00));
  assign w_need_hi    = 1'b0;
  assign w_error      = (w_size == 2'd3) || w_misaligned;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_next_state = w_error ? RESPOND : ACCESS_LO;
        end else begin
          w_next_state = IDLE;
        end
      end
      ACCESS_LO: begin
        if (w_write) begin
          w_next_state = w_need_hi ? ACCESS_HI : RESPOND;
        end else begin
          w_next_state = CAPTURE_LO;
        end
      end
      CAPTURE_LO: w_next_state = w_need_hi ? ACCESS_HI : RESPOND;
      ACCESS_HI:  w_next_state = w_write ? RESPOND : CAPTURE_HI;
      CAPTURE_HI: w_next_state = RESPOND;
      RESPOND:    w_next_state = IDLE;
      default:    w_next_state = IDLE;
    endcase
  end

  // Little-endian reassembly: bytes 0..6 of {hi, lo} are enough for any offset.
  always_comb begin
    w_rd56 = {24'h00_0000, bus_read_data};
    if (r_state == CAPTURE_HI) begin
      w_rd56 = {bus_read_data[23:0], r_lo};
    end else begin
      w_rd56 = {24'h00_0000, bus_read_data};
    end
    case (r_addr[1:0])
      2'd0:    w_raw = w_rd56[31:0];
      2'd1:    w_raw = w_rd56[39:8];
      2'd2:    w_raw = w_rd56[47:16];
      2'd3:    w_raw = w_rd56[55:24];
      default: w_raw = w_rd56[31:0];
    endcase
    case (r_size)
      2'd0:    w_ext = r_unsigned ? {24'h00_0000, w_raw[7:0]}  : {{24{w_raw[7]}}, w_raw[7:0]};
      2'd1:    w_ext = r_unsigned ? {16'h0000, w_raw[15:0]}    : {{16{w_raw[15]}}, w_raw[15:0]};
      default: w_ext = w_raw;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state          <= IDLE;
      r_write          <= 1'b0;
      r_unsigned       <= 1'b0;
      r_size           <= 2'd0;
      r_addr           <= 32'h0000_0000;
      r_wdata          <= 32'h0000_0000;
      r_lo             <= 32'h0000_0000;
      resp_valid       <= 1'b0;
      resp_error       <= 1'b0;
      resp_read_data   <= 32'h0000_0000;
      bus_address      <= 32'h0000_0000;
      bus_write_data   <= 32'h0000_0000;
      bus_byte_enable  <= 4'b0000;
      bus_read_enable  <= 1'b0;
      bus_write_enable <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_idle && req_valid) begin
        r_write    <= req_write;
        r_unsigned <= req_unsigned;
        r_size     <= req_size;
        r_addr     <= req_address;
        r_wdata    <= req_write_data;
      end
      if (r_state == CAPTURE_LO) begin
        r_lo <= bus_read_data;
      end
      case (w_next_state)
        ACCESS_LO, CAPTURE_LO: begin
          bus_address      <= w_word_addr;
          bus_byte_enable  <= w_be8[3:0];
          bus_write_data   <= w_write ? w_wdata64[31:0] : 32'h0000_0000;
          bus_read_enable  <= ~w_write;
          bus_write_enable <= w_write && (w_next_state == ACCESS_LO);
        end
        ACCESS_HI, CAPTURE_HI: begin
          bus_address      <= w_word_addr + 32'd4;
          bus_byte_enable  <= w_be8[7:4];
          bus_write_data   <= w_write ? w_wdata64[63:32] : 32'h0000_0000;
          bus_read_enable  <= ~w_write;
          bus_write_enable <= w_write && (w_next_state == ACCESS_HI);
        end
        default: begin
          bus_address      <= 32'h0000_0000;
          bus_byte_enable  <= 4'b0000;
          bus_write_data   <= 32'h0000_0000;
          bus_read_enable  <= 1'b0;
          bus_write_enable <= 1'b0;
        end
      endcase
      // Entering RESPOND straight from IDLE can only mean a rejected request.
      if (w_next_state == RESPOND) begin
        resp_valid     <= 1'b1;
        resp_error     <= w_idle;
        resp_read_data <= (!w_write && !w_idle) ? w_ext : 32'h0000_0000;
      end else begin
        resp_valid     <= 1'b0;
        resp_error     <= 1'b0;
        resp_read_data <= 32'h0000_0000;
      end
    end
  end

endmodule
